// File: rtl/alu_share_arbiter_if.sv
// Bundles the two requester ports, the shared ALU drive/return and the response bus.
// Latency: none (wiring only).
// Backpressure: requesters hold req/op/a/b until their one-cycle gnt pulse.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic [2:0]       op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             gnt0;
    logic             req1;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt1;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_sel;
    logic             alu_binvert;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;

    // Environment side: requesters plus the combinational ALU.
    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_result,
        input  gnt0, gnt1, alu_a, alu_b, alu_sel, alu_binvert,
        input  rsp_valid, rsp_id, rsp_result, rsp_err
    );

    // Arbiter side.
    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_result,
        output gnt0, gnt1, alu_a, alu_b, alu_sel, alu_binvert,
        output rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, tagged response bus.
// Latency: 2 cycles gnt -> rsp_valid; one operation every 3 cycles.
// Backpressure: requests are only sampled in IDLE; losers simply keep req held.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             last_gnt;
    logic             lat_id;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [1:0]       lat_sel;
    logic             lat_binv;
    logic             lat_err;
    logic             rsp_id_q;
    logic             rsp_err_q;
    logic [WIDTH-1:0] rsp_result_q;

    logic             pick1;
    logic             grant;
    logic [2:0]       win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [1:0]       dec_sel;
    logic             dec_binv;
    logic             dec_err;
    logic             drive_alu;

    // Arbitration: requester 1 wins if alone, or on a tie when 0 went last.
    // The grant is gated by rst_n so gnt stays low throughout reset.
    always_comb begin
        pick1  = bus.req1 && (!bus.req0 || !last_gnt);
        grant  = rst_n && (state == IDLE) && (bus.req0 || bus.req1);
        win_op = pick1 ? bus.op1 : bus.op0;
        win_a  = pick1 ? bus.a1  : bus.a0;
        win_b  = pick1 ? bus.b1  : bus.b0;
    end

    // Op decode of the winning request into mux select and subtract control.
    always_comb begin
        dec_sel  = 2'b00;
        dec_binv = 1'b0;
        dec_err  = 1'b0;
        case (win_op)
            3'b000:  begin dec_sel = 2'b00; dec_binv = 1'b0; end
            3'b001:  begin dec_sel = 2'b01; dec_binv = 1'b0; end
            3'b010:  begin dec_sel = 2'b10; dec_binv = 1'b0; end
            3'b110:  begin dec_sel = 2'b10; dec_binv = 1'b1; end
            3'b111:  begin dec_sel = 2'b11; dec_binv = 1'b1; end
            default: dec_err = 1'b1;
        endcase
    end

    // IDLE -> EXEC -> RESP -> IDLE; latch on grant, capture ALU result in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_gnt     <= 1'b1;
            lat_id       <= 1'b0;
            lat_a        <= '0;
            lat_b        <= '0;
            lat_sel      <= 2'b00;
            lat_binv     <= 1'b0;
            lat_err      <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        lat_id   <= pick1;
                        lat_a    <= win_a;
                        lat_b    <= win_b;
                        lat_sel  <= dec_sel;
                        lat_binv <= dec_binv;
                        lat_err  <= dec_err;
                        last_gnt <= pick1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= lat_err ? '0 : bus.alu_result;
                    rsp_id_q     <= lat_id;
                    rsp_err_q    <= lat_err;
                    state        <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The ALU only sees operands while a legal op is executing.
    assign drive_alu       = (state == EXEC) && !lat_err;
    assign bus.alu_a       = drive_alu ? lat_a : '0;
    assign bus.alu_b       = drive_alu ? lat_b : '0;
    assign bus.alu_sel     = drive_alu ? lat_sel : 2'b00;
    assign bus.alu_binvert = drive_alu && lat_binv;

    assign bus.gnt0       = grant && !pick1;
    assign bus.gnt1       = grant && pick1;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU datapath between two requesters: the adder/logic slice plus the 4:1 result mux that selects and/or/sum/less.
- Arbitrates round-robin, decodes a 3-bit op into the mux select and the B-invert/carry-in control, drives the ALU, and captures the ALU result.
- Returns the result on a shared response bus tagged with the requester ID.
- Sits between the issue logic (two contexts) and the combinational ALU in the MIPS datapath.

Parameters:
- WIDTH, 32, operand/result width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request; held with op0/a0/b0 until gnt0
- op0  in  3  requester 0 operation
- a0  in  WIDTH  requester 0 operand A
- b0  in  WIDTH  requester 0 operand B
- gnt0  out  1  one-cycle accept pulse for requester 0
- req1, op1, a1, b1, gnt1  same as requester 0, for requester 1
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_sel  out  2  result-mux select: 00 and, 01 or, 10 sum, 11 less
- alu_binvert  out  1  invert B and carry-in 1 (subtract)
- alu_result  in  WIDTH  combinational ALU/mux output
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  1  requester that owns the response
- rsp_result  out  WIDTH  captured result; held until the next rsp_valid
- rsp_err  out  1  illegal op, qualified by rsp_valid

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0 and after release, all of the following are 0:
  - state=IDLE, gnt0, gnt1, alu_a, alu_b, alu_sel, alu_binvert, rsp_valid, rsp_id, rsp_result, rsp_err
  - last_gnt=1, so requester 0 wins the first contest.
- Op decode (op -> alu_sel, alu_binvert):
  - 000 AND -> 00, 0
  - 001 OR -> 01, 0
  - 010 ADD -> 10, 0
  - 110 SUB -> 10, 1
  - 111 SLT -> 11, 1
  - Any other code is illegal.
- State machine: IDLE -> EXEC -> RESP -> IDLE. One operation every 3 cycles; latency is 2 cycles from the gnt cycle to the rsp_valid cycle.
- IDLE:
  - No req: stay in IDLE, all strobes 0.
  - Exactly one req: grant that requester.
  - req0 and req1 both asserted: grant the requester != last_gnt.
  - On grant: gntX=1 for this cycle only; latch opX/aX/bX and the ID; last_gnt<=X; go to EXEC.
- EXEC:
  - alu_a/alu_b = latched operands; alu_sel/alu_binvert from the decode.
  - At the clock edge, rsp_result<=alu_result, rsp_id<=ID, rsp_err<=0; go to RESP.
  - Illegal op: ALU outputs are driven 0, rsp_result<=0, rsp_err<=1.
- RESP: rsp_valid=1 for this cycle; ALU outputs 0; go to IDLE. Requests are not sampled in RESP or EXEC.
- ALU outputs are 0 in IDLE and RESP.
- Request rules:
  - A requester may drop req before it is granted, and nothing is latched.
  - A requester must drop req in the cycle after gnt. If req is still high on a later IDLE cycle, that is a new request.
- Results are the raw ALU result; this block does no overflow detection. For SLT the ALU supplies 0 or 1 in bit 0.
- Reset mid-operation (EXEC or RESP):
  - The operation is aborted with no rsp_valid; all outputs return to their reset values.
  - The requester reissues after reset.

Test Plan:
- Reset, then req0=1, op0=010, a0=32'h11111111, b0=32'h22222222 -> gnt0 at cycle t; at t+1 alu_sel=10, alu_binvert=0; at t+2 rsp_valid=1, rsp_id=0, rsp_result=32'h33333333.
- req0 and req1 asserted together every IDLE cycle (req0 op=000 a=32'hFFFF0000 b=32'h0F0F0F0F; req1 op=001 a=32'h11111111 b=32'h22222222):
  - Grant order is 0,1,0,1.
  - rsp_result alternates 32'h0F0F0000 and 32'h33333333.
  - Responses are 3 cycles apart.
- req1 op=111, a=32'h00000003, b=32'h00000005 -> alu_sel=11, alu_binvert=1 during EXEC; rsp_result=32'h00000001, rsp_id=1. Repeat with a=5, b=3 -> rsp_result=0.
- req0 op=110, a=0, b=1 -> rsp_result=32'hFFFFFFFF. Then op0=011 -> rsp_valid with rsp_err=1, rsp_result=0, and alu_a/alu_b stay 0 during EXEC.
- Pull rst_n low during EXEC of a granted op -> all outputs 0 immediately and no rsp_valid. After release, req0 and req1 asserted together -> gnt0 first.
